// File: rtl/uart_rx_frame_checker.sv
// UART RX frame checker: validates start, optional parity and one/two stop bits,
// deserialises the data field LSB first and keeps saturating error counters.
module uart_rx_frame_checker #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned COUNTER_WIDTH = 4,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     frame_start,
  input  logic                     valid_sampled_bit,
  input  logic                     sampled_bit,
  input  logic                     PAR_EN,
  input  logic                     PAR_TYP,
  input  logic                     STOP2_EN,
  input  logic                     clear_counters,
  output logic [DATA_WIDTH-1:0]    P_DATA,
  output logic                     DATA_VALID,
  output logic                     frame_done,
  output logic                     STRT_GLITCH,
  output logic                     PAR_ERR,
  output logic                     STP_ERR,
  output logic                     busy,
  output logic [ERR_CNT_WIDTH-1:0] par_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] stp_err_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;

  localparam logic [COUNTER_WIDTH-1:0] LAST_BIT = COUNTER_WIDTH'(DATA_WIDTH - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX  = {ERR_CNT_WIDTH{1'b1}};

  logic [2:0]               r_state;
  logic [COUNTER_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0]    r_shift;
  logic                     r_par_en;
  logic                     r_par_typ;
  logic                     r_stop2_en;
  logic                     r_strt_glitch;
  logic                     r_par_err;
  logic                     r_stp_err;
  logic [DATA_WIDTH-1:0]    r_p_data;
  logic                     r_data_valid;
  logic                     r_frame_done;
  logic                     r_busy;
  logic [ERR_CNT_WIDTH-1:0] r_par_cnt;
  logic [ERR_CNT_WIDTH-1:0] r_stp_cnt;

  logic [2:0]               w_state;
  logic [COUNTER_WIDTH-1:0] w_cnt;
  logic [DATA_WIDTH-1:0]    w_shift;
  logic                     w_par_en;
  logic                     w_par_typ;
  logic                     w_stop2_en;
  logic                     w_strt_glitch;
  logic                     w_par_err;
  logic                     w_stp_err;
  logic                     w_finish;
  logic                     w_good;
  logic                     w_exp_par;
  logic [ERR_CNT_WIDTH-1:0] w_par_cnt;
  logic [ERR_CNT_WIDTH-1:0] w_stp_cnt;

  // Expected parity bit for the deserialised word; odd type inverts it.
  assign w_exp_par = (^r_shift) ^ r_par_typ;

  // Next-state and frame bookkeeping; frame_start overrides any pending bit.
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_shift       = r_shift;
    w_par_en      = r_par_en;
    w_par_typ     = r_par_typ;
    w_stop2_en    = r_stop2_en;
    w_strt_glitch = r_strt_glitch;
    w_par_err     = r_par_err;
    w_stp_err     = r_stp_err;
    w_finish      = 1'b0;
    if (frame_start) begin
      w_state       = START;
      w_cnt         = '0;
      w_shift       = '0;
      w_par_en      = PAR_EN;
      w_par_typ     = PAR_TYP;
      w_stop2_en    = STOP2_EN;
      w_strt_glitch = 1'b0;
      w_par_err     = 1'b0;
      w_stp_err     = 1'b0;
    end else if (valid_sampled_bit) begin
      case (r_state)
        START: begin
          if (sampled_bit) begin
            w_strt_glitch = 1'b1;
            w_state       = IDLE;
          end else begin
            w_state = DATA;
          end
        end
        DATA: begin
          w_shift = {sampled_bit, r_shift[DATA_WIDTH-1:1]};
          w_cnt   = r_cnt + COUNTER_WIDTH'(1);
          if (r_cnt == LAST_BIT) begin
            w_state = r_par_en ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (sampled_bit != w_exp_par) begin
            w_par_err = 1'b1;
          end
          w_state = STOP1;
        end
        STOP1: begin
          if (!sampled_bit) begin
            w_stp_err = 1'b1;
          end
          if (r_stop2_en) begin
            w_state = STOP2;
          end else begin
            w_state  = IDLE;
            w_finish = 1'b1;
          end
        end
        STOP2: begin
          if (!sampled_bit) begin
            w_stp_err = 1'b1;
          end
          w_state  = IDLE;
          w_finish = 1'b1;
        end
        default: w_state = IDLE;
      endcase
    end
  end

  assign w_good = w_finish & ~w_par_err & ~w_stp_err;

  // Saturating error counters; a clear beats a same-cycle increment.
  always_comb begin
    w_par_cnt = r_par_cnt;
    w_stp_cnt = r_stp_cnt;
    if (clear_counters) begin
      w_par_cnt = '0;
      w_stp_cnt = '0;
    end else if (w_finish) begin
      if (w_par_err && (r_par_cnt != CNT_MAX)) begin
        w_par_cnt = r_par_cnt + ERR_CNT_WIDTH'(1);
      end
      if (w_stp_err && (r_stp_cnt != CNT_MAX)) begin
        w_stp_cnt = r_stp_cnt + ERR_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_par_en      <= 1'b0;
      r_par_typ     <= 1'b0;
      r_stop2_en    <= 1'b0;
      r_strt_glitch <= 1'b0;
      r_par_err     <= 1'b0;
      r_stp_err     <= 1'b0;
      r_p_data      <= '0;
      r_data_valid  <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_par_cnt     <= '0;
      r_stp_cnt     <= '0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_shift       <= w_shift;
      r_par_en      <= w_par_en;
      r_par_typ     <= w_par_typ;
      r_stop2_en    <= w_stop2_en;
      r_strt_glitch <= w_strt_glitch;
      r_par_err     <= w_par_err;
      r_stp_err     <= w_stp_err;
      r_data_valid  <= w_good;
      r_frame_done  <= w_finish;
      r_busy        <= (w_state != IDLE);
      r_par_cnt     <= w_par_cnt;
      r_stp_cnt     <= w_stp_cnt;
      if (w_good) begin
        r_p_data <= r_shift;
      end
    end
  end

  assign P_DATA      = r_p_data;
  assign DATA_VALID  = r_data_valid;
  assign frame_done  = r_frame_done;
  assign STRT_GLITCH = r_strt_glitch;
  assign PAR_ERR     = r_par_err;
  assign STP_ERR     = r_stp_err;
  assign busy        = r_busy;
  assign par_err_cnt = r_par_cnt;
  assign stp_err_cnt = r_stp_cnt;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Directed bench for uart_rx_frame_checker with hand-computed expectations.
module tb_uart_rx_frame_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       frame_start = 1'b0;
  logic       valid_sampled_bit = 1'b0;
  logic       sampled_bit = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2_EN = 1'b0;
  logic       clear_counters = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       frame_done;
  logic       STRT_GLITCH;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       busy;
  logic [7:0] par_err_cnt;
  logic [7:0] stp_err_cnt;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int dv_cnt = 0;
  int done_ref;
  int dv_ref;

  uart_rx_frame_checker #(
    .DATA_WIDTH(8), .COUNTER_WIDTH(4), .ERR_CNT_WIDTH(8)
  ) dut (
    .CLK(CLK), .RST(RST), .frame_start(frame_start),
    .valid_sampled_bit(valid_sampled_bit), .sampled_bit(sampled_bit),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2_EN(STOP2_EN),
    .clear_counters(clear_counters), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .frame_done(frame_done), .STRT_GLITCH(STRT_GLITCH), .PAR_ERR(PAR_ERR),
    .STP_ERR(STP_ERR), .busy(busy), .par_err_cnt(par_err_cnt),
    .stp_err_cnt(stp_err_cnt)
  );

  always #5 CLK = ~CLK;

  // Pulse tallies: each one-cycle pulse is seen at exactly one rising edge.
  always @(posedge CLK) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (DATA_VALID) dv_cnt <= dv_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) @(negedge CLK);
    valid_sampled_bit = 1'b1;
    sampled_bit = b;
    @(negedge CLK);
    valid_sampled_bit = 1'b0;
    sampled_bit = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge CLK);
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic has_par, input logic par_bit,
                            input logic has_s2, input logic s1, input logic s2, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(data[i], gap);
    if (has_par) send_bit(par_bit, gap);
    send_bit(s1, gap);
    if (has_s2) send_bit(s2, gap);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    check_val("rst_pdata", 32'(P_DATA), 32'h0);
    check_val("rst_flags", 32'({DATA_VALID, frame_done, STRT_GLITCH, PAR_ERR, STP_ERR, busy}), 32'h0);
    check_val("rst_cnts", 32'({par_err_cnt, stp_err_cnt}), 32'h0);
    RST = 1'b1;
    @(negedge CLK);

    // Good frame 0xA5, no parity, one stop bit
    pulse_start();
    check_val("a5_busy", 32'(busy), 32'h1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    check_val("a5_done", 32'(frame_done), 32'h1);
    check_val("a5_dv", 32'(DATA_VALID), 32'h1);
    check_val("a5_pdata", 32'(P_DATA), 32'hA5);
    check_val("a5_flags", 32'({STRT_GLITCH, PAR_ERR, STP_ERR, busy}), 32'h0);
    @(negedge CLK);
    check_val("a5_pulse_w", 32'({frame_done, DATA_VALID}), 32'h0);
    check_val("a5_done_cnt", 32'(done_cnt), 32'd1);
    check_val("a5_dv_cnt", 32'(dv_cnt), 32'd1);

    // Even parity, data 0x07 (three ones) expects parity 1; send 0
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    pulse_start();
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(i < 3, 1);
    send_bit(1'b0, 2);
    check_val("par_err_early", 32'(PAR_ERR), 32'h1);
    send_bit(1'b1, 0);
    check_val("par_done", 32'(frame_done), 32'h1);
    check_val("par_no_dv", 32'(DATA_VALID), 32'h0);
    check_val("par_pdata_hold", 32'(P_DATA), 32'hA5);
    check_val("par_cnt", 32'(par_err_cnt), 32'd1);
    check_val("par_stp", 32'({STP_ERR, stp_err_cnt}), 32'h0);

    // Odd parity, 0x07 expects parity 0: good frame
    PAR_TYP = 1'b1;
    pulse_start();
    check_val("odd_flag_clr", 32'(PAR_ERR), 32'h0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    check_val("odd_dv", 32'(DATA_VALID), 32'h1);
    check_val("odd_pdata", 32'(P_DATA), 32'h07);
    check_val("odd_par_cnt", 32'(par_err_cnt), 32'd1);

    // Two stop bits: 1 then 0, then 0 then 1 (sticky)
    PAR_EN = 1'b0; STOP2_EN = 1'b1;
    pulse_start();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    check_val("s2_stp_err", 32'(STP_ERR), 32'h1);
    check_val("s2_stp_cnt", 32'(stp_err_cnt), 32'd1);
    check_val("s2_no_dv", 32'({frame_done, DATA_VALID}), 32'h2);
    pulse_start();
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(i >= 2 && i <= 5, 0);
    send_bit(1'b0, 0);
    check_val("s1_err_early", 32'({STP_ERR, frame_done}), 32'h2);
    send_bit(1'b1, 0);
    check_val("s1_sticky", 32'({STP_ERR, frame_done, DATA_VALID}), 32'h6);
    check_val("s1_stp_cnt", 32'(stp_err_cnt), 32'd2);
    check_val("s1_pdata", 32'(P_DATA), 32'h07);

    // Start glitch
    STOP2_EN = 1'b0;
    @(negedge CLK);
    done_ref = done_cnt;
    pulse_start();
    send_bit(1'b1, 0);
    check_val("glitch_flag", 32'(STRT_GLITCH), 32'h1);
    check_val("glitch_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge CLK);
    check_val("glitch_no_done", 32'(done_cnt), 32'(done_ref));
    check_val("glitch_cnts", 32'({par_err_cnt, stp_err_cnt}), 32'h0102);
    pulse_start();
    check_val("glitch_clr", 32'(STRT_GLITCH), 32'h0);

    // Saturation: 253 more stop errors reach 0xFF, one more stays
    for (int f = 0; f < 253; f++) begin
      pulse_start();
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    check_val("sat_ff", 32'(stp_err_cnt), 32'hFF);
    pulse_start();
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_val("sat_hold", 32'(stp_err_cnt), 32'hFF);
    check_val("sat_par", 32'(par_err_cnt), 32'd1);

    // clear_counters on the same edge as an increment
    pulse_start();
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 0);
    clear_counters = 1'b1;
    send_bit(1'b0, 0);
    clear_counters = 1'b0;
    check_val("clr_stp", 32'(stp_err_cnt), 32'h0);
    check_val("clr_par", 32'(par_err_cnt), 32'h0);
    check_val("clr_done", 32'(frame_done), 32'h1);

    // Abort mid-DATA, then full 0x5A; PAR_EN raised after arming is ignored
    @(negedge CLK);
    done_ref = done_cnt;
    dv_ref = dv_cnt;
    pulse_start();
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    pulse_start();
    PAR_EN = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    check_val("abort_pdata", 32'(P_DATA), 32'h5A);
    check_val("abort_dv", 32'(DATA_VALID), 32'h1);
    // New frame armed while frame_done is high
    frame_start = 1'b1;
    @(negedge CLK);
    frame_start = 1'b0;
    check_val("rearm_busy", 32'(busy), 32'h1);
    check_val("abort_done_cnt", 32'(done_cnt - done_ref), 32'd1);
    check_val("abort_dv_cnt", 32'(dv_cnt - dv_ref), 32'd1);

    // Async reset mid-frame
    PAR_EN = 1'b0;
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    check_val("mid_busy", 32'(busy), 32'h1);
    #2 RST = 1'b0;
    #1;
    check_val("arst_pdata", 32'(P_DATA), 32'h0);
    check_val("arst_flags", 32'({DATA_VALID, frame_done, STRT_GLITCH, PAR_ERR, STP_ERR, busy}), 32'h0);
    check_val("arst_cnts", 32'({par_err_cnt, stp_err_cnt}), 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
